// File: rtl/digit_row_if.sv
`default_nettype none
// ============================================================================
// Module      : digit_row_if
// Description : Raster/glyph bundle between the VGA timing generator, the
//               digit_row renderer and the colour mux.
//               master : drives hcount, vcount, digits; receives pixel_on,
//                        in_field.
//               slave  : the renderer (digit_row).
//               hcount/vcount : raster x/y, COORD_W bits each.
//               digits        : 4*NUM_DIGITS glyph codes, digit 0 in [3:0].
//               pixel_on      : glyph pixel lit (registered in the renderer).
//               in_field      : raster inside the glyph field (registered).
// Revision    : 1.0 - initial release
// ============================================================================
interface digit_row_if #(
  parameter int NUM_DIGITS = 4,
  parameter int COORD_W    = 10
);
  logic [COORD_W-1:0]      hcount;
  logic [COORD_W-1:0]      vcount;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    pixel_on;
  logic                    in_field;

  modport master (
    output hcount, vcount, digits,
    input  pixel_on, in_field
  );

  modport slave (
    input  hcount, vcount, digits,
    output pixel_on, in_field
  );
endinterface
`default_nettype wire

// File: rtl/digit_row.sv
`default_nettype none
// ============================================================================
// Module      : digit_row
// Description : Renders a row of NUM_DIGITS 3x5 block-font glyphs straight
//               from the raster position. Each font block is BLOCK_PX square,
//               each glyph is followed by one blank block column. Position
//               inside the field is tracked with counters (no division), and
//               the glyph codes are shadowed once per frame to avoid tearing.
//               Outputs lag hcount/vcount by two clocks.
//   clk       : pixel clock, one raster pixel per cycle
//   reset     : synchronous, active-high
//   bus       : digit_row_if.slave (hcount, vcount, digits in;
//               pixel_on, in_field out)
// Revision    : 1.0 - initial release
// ============================================================================
module digit_row #(
  parameter int NUM_DIGITS = 4,
  parameter int BLOCK_PX   = 8,
  parameter int X_ORIGIN   = 64,
  parameter int Y_ORIGIN   = 32,
  parameter int COORD_W    = 10
) (
  input  logic       clk,
  input  logic       reset,
  digit_row_if.slave bus
);

  localparam int c_fw     = NUM_DIGITS * 4 * BLOCK_PX;
  localparam int c_fh     = 5 * BLOCK_PX;
  localparam int c_sub_w  = (BLOCK_PX > 1) ? $clog2(BLOCK_PX) : 1;
  localparam int c_idx_w  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_cmp_w  = COORD_W + 1;

  // One extra bit so X_ORIGIN+FW may reach the top of the coordinate range.
  localparam logic [c_cmp_w-1:0] c_x_lo = c_cmp_w'(X_ORIGIN);
  localparam logic [c_cmp_w-1:0] c_x_hi = c_cmp_w'(X_ORIGIN + c_fw);
  localparam logic [c_cmp_w-1:0] c_y_lo = c_cmp_w'(Y_ORIGIN);
  localparam logic [c_cmp_w-1:0] c_y_hi = c_cmp_w'(Y_ORIGIN + c_fh);

  localparam logic [COORD_W-1:0] c_x_org   = COORD_W'(X_ORIGIN);
  localparam logic [COORD_W-1:0] c_y_org   = COORD_W'(Y_ORIGIN);
  localparam logic [c_sub_w-1:0] c_sub_max = c_sub_w'(BLOCK_PX - 1);
  localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(NUM_DIGITS - 1);

  // 3x5 font, rows top to bottom, MSB of each row is the leftmost column.
  function automatic logic [2:0] font_row(input logic [3:0] code, input logic [2:0] row);
    logic [14:0] glyph;
    logic [2:0]  bits;
    case (code)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b010_110_010_010_111;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      4'd9:    glyph = 15'b111_101_111_001_111;
      4'd10:   glyph = 15'b000_010_000_010_000;
      default: glyph = 15'b000_000_000_000_000;
    endcase
    case (row)
      3'd0:    bits = glyph[14:12];
      3'd1:    bits = glyph[11:9];
      3'd2:    bits = glyph[8:6];
      3'd3:    bits = glyph[5:3];
      3'd4:    bits = glyph[2:0];
      default: bits = 3'b000;
    endcase
    return bits;
  endfunction

  // Raster decode
  logic w_h_in, w_v_in, w_line_start, w_y_top, w_frame_start;

  assign w_h_in        = ({1'b0, bus.hcount} >= c_x_lo) && ({1'b0, bus.hcount} < c_x_hi);
  assign w_v_in        = ({1'b0, bus.vcount} >= c_y_lo) && ({1'b0, bus.vcount} < c_y_hi);
  assign w_line_start  = (bus.hcount == c_x_org);
  assign w_y_top       = (bus.vcount == c_y_org);
  assign w_frame_start = (bus.hcount == '0) && (bus.vcount == '0);

  // State
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [c_sub_w-1:0]      x_sub_q, x_sub_d;
  logic [1:0]              x_col_q, x_col_d;
  logic [c_idx_w-1:0]      d_idx_q, d_idx_d;
  logic [c_sub_w-1:0]      y_sub_q, y_sub_d;
  logic [2:0]              y_row_q, y_row_d;
  logic [c_idx_w-1:0]      d_idx_s1_q, d_idx_s1_d;
  logic [1:0]              x_col_s1_q, x_col_s1_d;
  logic [2:0]              y_row_s1_q, y_row_s1_d;
  logic                    fld_s1_q, fld_s1_d;
  logic                    pixel_on_q, pixel_on_d;
  logic                    in_field_q, in_field_d;

  // Position of the pixel currently on hcount/vcount. The counter flops hold
  // the position for the *next* pixel, so the clear at the field edge is
  // applied combinationally to give a valid position on that same pixel.
  logic [c_sub_w-1:0] w_cur_x_sub, w_cur_y_sub;
  logic [1:0]         w_cur_x_col;
  logic [c_idx_w-1:0] w_cur_d_idx;
  logic [2:0]         w_cur_y_row;

  always_comb begin
    shadow_d = shadow_q;
    if (w_frame_start) begin
      shadow_d = bus.digits;
    end
  end

  // Horizontal block/column/digit counters
  always_comb begin
    w_cur_x_sub = x_sub_q;
    w_cur_x_col = x_col_q;
    w_cur_d_idx = d_idx_q;
    if (w_line_start) begin
      w_cur_x_sub = '0;
      w_cur_x_col = '0;
      w_cur_d_idx = '0;
    end

    x_sub_d = w_cur_x_sub;
    x_col_d = w_cur_x_col;
    d_idx_d = w_cur_d_idx;
    if (w_h_in) begin
      if (w_cur_x_sub == c_sub_max) begin
        x_sub_d = '0;
        x_col_d = w_cur_x_col + 2'd1;
        if (w_cur_x_col == 2'd3) begin
          d_idx_d = (w_cur_d_idx == c_idx_max) ? '0 : w_cur_d_idx + 1'b1;
        end
      end else begin
        x_sub_d = w_cur_x_sub + 1'b1;
      end
    end
  end

  // Vertical counters advance once per line, at the field's left edge.
  always_comb begin
    w_cur_y_sub = y_sub_q;
    w_cur_y_row = y_row_q;
    if (w_line_start) begin
      if (w_y_top) begin
        w_cur_y_sub = '0;
        w_cur_y_row = '0;
      end else if (w_v_in) begin
        if (y_sub_q == c_sub_max) begin
          w_cur_y_sub = '0;
          w_cur_y_row = y_row_q + 3'd1;
        end else begin
          w_cur_y_sub = y_sub_q + 1'b1;
        end
      end
    end
    y_sub_d = w_cur_y_sub;
    y_row_d = w_cur_y_row;
  end

  // Stage 1: capture position; stage 2: font lookup
  logic [3:0] w_code;
  logic [2:0] w_glyph_row;
  logic       w_font_bit;

  always_comb begin
    d_idx_s1_d = w_cur_d_idx;
    x_col_s1_d = w_cur_x_col;
    y_row_s1_d = w_cur_y_row;
    fld_s1_d   = w_h_in && w_v_in;

    w_code      = shadow_q[{d_idx_s1_q, 2'b00} +: 4];
    w_glyph_row = font_row(w_code, y_row_s1_q);
    case (x_col_s1_q)
      2'd0:    w_font_bit = w_glyph_row[2];
      2'd1:    w_font_bit = w_glyph_row[1];
      2'd2:    w_font_bit = w_glyph_row[0];
      default: w_font_bit = 1'b0;  // gap column
    endcase

    pixel_on_d = fld_s1_q && w_font_bit;
    in_field_d = fld_s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '1;
      x_sub_q    <= '0;
      x_col_q    <= '0;
      d_idx_q    <= '0;
      y_sub_q    <= '0;
      y_row_q    <= '0;
      d_idx_s1_q <= '0;
      x_col_s1_q <= '0;
      y_row_s1_q <= '0;
      fld_s1_q   <= 1'b0;
      pixel_on_q <= 1'b0;
      in_field_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      x_sub_q    <= x_sub_d;
      x_col_q    <= x_col_d;
      d_idx_q    <= d_idx_d;
      y_sub_q    <= y_sub_d;
      y_row_q    <= y_row_d;
      d_idx_s1_q <= d_idx_s1_d;
      x_col_s1_q <= x_col_s1_d;
      y_row_s1_q <= y_row_s1_d;
      fld_s1_q   <= fld_s1_d;
      pixel_on_q <= pixel_on_d;
      in_field_q <= in_field_d;
    end
  end

  assign bus.pixel_on = pixel_on_q;
  assign bus.in_field = in_field_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_row.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_row
// Description : Self-checking bench for digit_row (4 digits, 4-pixel blocks,
//               field origin 100,50). The raster is 168 pixels wide; vertical
//               blanking is shortened to line 0 (frame latch) followed by
//               lines 46..71, which keeps each frame short while still
//               passing through every field boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_row;

  localparam int NUM_DIGITS = 4;
  localparam int BLOCK_PX   = 4;
  localparam int X_ORIGIN   = 100;
  localparam int Y_ORIGIN   = 50;
  localparam int COORD_W    = 10;
  localparam int H_TOTAL    = 168;
  localparam int V_LAST     = 71;

  logic clk;
  logic reset;

  digit_row_if #(.NUM_DIGITS(NUM_DIGITS), .COORD_W(COORD_W)) bus ();

  digit_row #(
    .NUM_DIGITS(NUM_DIGITS),
    .BLOCK_PX  (BLOCK_PX),
    .X_ORIGIN  (X_ORIGIN),
    .Y_ORIGIN  (Y_ORIGIN),
    .COORD_W   (COORD_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Captured outputs, indexed by the raster position that produced them.
  logic cap_on  [0:V_LAST][0:H_TOTAL-1];
  logic cap_fld [0:V_LAST][0:H_TOTAL-1];
  int   prev_h, prev_v;
  bit   prev_valid = 1'b0;
  logic [15:0] shadow_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Spec font table, row 0 in bits [14:12], MSB = leftmost column.
  function automatic logic [14:0] glyph_m(input int code);
    case (code)
      0:  return 15'b111_101_101_101_111;
      1:  return 15'b010_110_010_010_111;
      2:  return 15'b111_001_111_100_111;
      3:  return 15'b111_001_111_001_111;
      4:  return 15'b101_101_111_001_001;
      5:  return 15'b111_100_111_001_111;
      6:  return 15'b111_100_111_101_111;
      7:  return 15'b111_001_001_001_001;
      8:  return 15'b111_101_111_101_111;
      9:  return 15'b111_101_111_001_111;
      10: return 15'b000_010_000_010_000;
      default: return 15'b0;
    endcase
  endfunction

  function automatic bit exp_fld(input int h, input int v);
    return (h >= 100) && (h < 164) && (v >= 50) && (v < 70);
  endfunction

  function automatic bit exp_on(input int h, input int v, input logic [15:0] sh);
    int d, col, row, code;
    logic [14:0] g;
    if (!exp_fld(h, v)) return 1'b0;
    d    = (h - 100) / 16;
    col  = ((h - 100) % 16) / 4;
    row  = (v - 50) / 4;
    if (col == 3) return 1'b0;
    code = int'((sh >> (4 * d)) & 16'hF);
    g    = glyph_m(code);
    return g[14 - 3 * row - col];
  endfunction

  // Present one pixel, clock it, then record the outputs that belong to the
  // previously presented pixel (two-clock latency).
  task automatic step(input int h, input int v);
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    @(posedge clk);
    #1;
    if (prev_valid) begin
      cap_on[prev_v][prev_h]  = bus.pixel_on;
      cap_fld[prev_v][prev_h] = bus.in_field;
    end
    prev_h = h;
    prev_v = v;
    prev_valid = 1'b1;
  endtask

  task automatic run_frame(input logic [15:0] d0, input logic [15:0] d1, input int chg_line);
    int v;
    bus.digits = d0;
    shadow_m   = d0;
    for (int li = 0; li < 27; li++) begin
      v = (li == 0) ? 0 : 45 + li;
      if (v == chg_line) bus.digits = d1;
      for (int h = 0; h < H_TOTAL; h++) step(h, v);
    end
  endtask

  // Compare the captured frame against the division-based model.
  task automatic check_frame(input string name);
    for (int v = 46; v <= V_LAST; v++) begin
      for (int h = 90; h < H_TOTAL - 1; h++) begin
        check_eq($sformatf("%s fld(%0d,%0d)", name, h, v), 32'(cap_fld[v][h]), 32'(exp_fld(h, v)));
        check_eq($sformatf("%s on(%0d,%0d)", name, h, v), 32'(cap_on[v][h]), 32'(exp_on(h, v, shadow_m)));
      end
    end
  endtask

  initial begin
    int lit;
    reset      = 1'b1;
    bus.digits = 16'h1111;

    // Reset for 3 clocks in the middle of line 46, then finish that frame.
    step(20, 46);
    step(21, 46);
    step(22, 46);
    check_eq("rst pixel_on", 32'(bus.pixel_on), 32'd0);
    check_eq("rst in_field", 32'(bus.in_field), 32'd0);
    reset = 1'b0;
    shadow_m = 16'hFFFF;
    for (int h = 23; h < H_TOTAL; h++) step(h, 46);
    for (int v = 47; v <= V_LAST; v++)
      for (int h = 0; h < H_TOTAL; h++) step(h, v);
    check_frame("blank");

    run_frame(16'h1111, 16'h1111, -1);
    check_eq("one (104,50)", 32'(cap_on[50][104]), 32'd1);
    check_eq("one (100,50)", 32'(cap_on[50][100]), 32'd0);
    check_eq("one (100,66)", 32'(cap_on[66][100]), 32'd1);
    check_frame("ones");

    run_frame(16'h8888, 16'h8888, -1);
    for (int h = 100; h < 112; h++)
      check_eq($sformatf("eight row0 x=%0d", h), 32'(cap_on[50][h]), 32'd1);
    for (int h = 112; h < 116; h++)
      check_eq($sformatf("eight gap x=%0d", h), 32'(cap_on[50][h]), 32'd0);
    check_eq("eight (116,50)", 32'(cap_on[50][116]), 32'd1);
    check_eq("bnd fld (99,50)",  32'(cap_fld[50][99]),  32'd0);
    check_eq("bnd on (99,50)",   32'(cap_on[50][99]),   32'd0);
    check_eq("bnd fld (164,50)", 32'(cap_fld[50][164]), 32'd0);
    check_eq("bnd on (164,50)",  32'(cap_on[50][164]),  32'd0);
    check_eq("bnd fld (100,49)", 32'(cap_fld[49][100]), 32'd0);
    check_eq("bnd on (100,49)",  32'(cap_on[49][100]),  32'd0);
    check_eq("bnd fld (100,70)", 32'(cap_fld[70][100]), 32'd0);
    check_eq("bnd on (100,70)",  32'(cap_on[70][100]),  32'd0);
    check_eq("bnd fld (163,69)", 32'(cap_fld[69][163]), 32'd1);
    check_eq("bnd on (163,69)",  32'(cap_on[69][163]),  32'd0);
    check_frame("eights");

    run_frame(16'hFFA0, 16'hFFA0, -1);
    check_eq("zero (104,54)",  32'(cap_on[54][104]), 32'd0);
    check_eq("colon (120,54)", 32'(cap_on[54][120]), 32'd1);
    check_eq("colon (120,50)", 32'(cap_on[50][120]), 32'd0);
    check_frame("colon");

    // Digits change mid-frame: still '0' until the next frame latch.
    run_frame(16'h0000, 16'h7777, 60);
    check_eq("tear (108,58)", 32'(cap_on[58][108]), 32'd1);
    check_eq("tear (100,58)", 32'(cap_on[58][100]), 32'd1);
    check_frame("tear");

    run_frame(16'h7777, 16'h7777, -1);
    check_eq("seven (108,58)", 32'(cap_on[58][108]), 32'd1);
    check_eq("seven (100,58)", 32'(cap_on[58][100]), 32'd0);
    check_frame("seven");

    // Every code 0-15, four per frame.
    run_frame(16'h3210, 16'h3210, -1);
    check_frame("codes0");
    run_frame(16'h7654, 16'h7654, -1);
    check_frame("codes4");
    run_frame(16'hBA98, 16'hBA98, -1);
    check_frame("codes8");
    run_frame(16'hFEDC, 16'hFEDC, -1);
    check_frame("codes12");
    lit = 0;
    for (int v = 50; v < 70; v++)
      for (int h = 100; h < 164; h++)
        if (cap_on[v][h] === 1'b1) lit++;
    check_eq("blank codes lit count", 32'(lit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_row.md
Name: digit_row

Overview:
- Renders a row of NUM_DIGITS blocky numeric glyphs directly from the VGA raster position.
- Each glyph is a 3x5 block font. Every block is BLOCK_PX x BLOCK_PX pixels, with one blank gap column after each glyph.
- Sits between the VGA timing generator and the colour mux; replaces the per-digit lookup and its external block-coordinate arithmetic.
- Position is tracked with counters, not division. A per-frame shadow register for the digit values prevents tearing.

Parameters:
- NUM_DIGITS, 4, glyphs in the row.
- BLOCK_PX, 8, pixels per font block edge (>=1, any integer).
- X_ORIGIN, 64, hcount of the field's left edge.
- Y_ORIGIN, 32, vcount of the field's top edge.
- COORD_W, 10, width of hcount/vcount.

Ports:
- clk  in  1  pixel clock; one raster pixel per cycle.
- reset  in  1  synchronous, active-high.
- hcount  in  COORD_W  raster x; increments by 1 per clk within a line.
- vcount  in  COORD_W  raster y.
- digits  in  4*NUM_DIGITS  glyph codes; digit 0 (leftmost) in bits [3:0].
- pixel_on  out  1  glyph pixel lit; registered.
- in_field  out  1  raster is inside the glyph field; registered, aligned with pixel_on.

Behaviour:
- Field geometry:
  - Width FW = NUM_DIGITS*4*BLOCK_PX; height FH = 5*BLOCK_PX.
  - h_in = X_ORIGIN <= hcount < X_ORIGIN+FW.
  - v_in = Y_ORIGIN <= vcount < Y_ORIGIN+FH.
- Glyph codes:
  - 0-9: decimal digits.
  - 10: colon.
  - 11-15: blank (all off).
- Font rows, top to bottom, 3 bits each, MSB = leftmost column:
  - 0: 111,101,101,101,111
  - 1: 010,110,010,010,111
  - 2: 111,001,111,100,111
  - 3: 111,001,111,001,111
  - 4: 101,101,111,001,001
  - 5: 111,100,111,001,111
  - 6: 111,100,111,101,111
  - 7: 111,001,001,001,001
  - 8: 111,101,111,101,111
  - 9: 111,101,111,001,111
  - 10: 000,010,000,010,000
- Shadow latch: when hcount==0 && vcount==0, shadow <= digits. Rendering uses only shadow; digits changes mid-frame are invisible until the next frame.
- Horizontal counters (x_sub 0..BLOCK_PX-1, x_col 0..3, d_idx 0..NUM_DIGITS-1):
  - Cleared when hcount==X_ORIGIN.
  - Otherwise, while h_in, x_sub increments. On wrap, x_col increments; on x_col wrap, d_idx increments.
  - Counters hold outside the field.
- Vertical counters (y_sub 0..BLOCK_PX-1, y_row 0..4):
  - Cleared at hcount==X_ORIGIN && vcount==Y_ORIGIN.
  - At hcount==X_ORIGIN on each later line with v_in, y_sub increments; on wrap, y_row increments.
- Pipeline, latency 2 cycles from hcount/vcount to outputs:
  - Stage 1 registers the counter-derived (d_idx, x_col, y_row) and h_in&&v_in.
  - Stage 2 does the font lookup and registers pixel_on and in_field.
- pixel_on is 1 only when in_field, x_col<3, and the font bit for shadow[d_idx], row y_row, column x_col is 1.
  - Gap column (x_col==3) is always 0.
  - Outside the field, always 0.
- Reset:
  - pixel_on=0, in_field=0, all counters 0, pipeline regs 0, shadow = all 4'hF (blank).
  - Reset mid-frame gives blank output until the next frame latch. The counters resync at the next hcount==X_ORIGIN without corruption.
- hcount jumps (non-raster stimulus) are not supported; output is undefined until the next line start.

Test Plan (NUM_DIGITS=4, BLOCK_PX=4, X_ORIGIN=100, Y_ORIGIN=50, full raster 800x525 wrapping):
- Reset held for 3 clks mid-line, then full frame with digits=16'h1111 → pixel_on=0 everywhere in that frame (shadow blank). In the next frame, pixel (104,50) → pixel_on=1 exactly 2 clks later; (100,50) → 0; (100,66) → 1 (row 4 = 111).
- digits=16'h8888 → in each glyph, the 3x4-pixel columns at x=100..111 of row 0 are lit. Gap x=112..115 is 0; x=116 is lit. in_field=1 for x=100..163, y=50..69 only.
- digits=16'hFFA0 → digit0 '0': (104,54) (row 1, col 1) = 0. Digit1 colon: (120,54) = 1, (120,50) = 0. Digits 2-3: 0 everywhere.
- Change digits from 16'h0000 to 16'h7777 at vcount=60 → rest of frame still renders '0'. Frame after hcount=0/vcount=0 renders '7': (108,58) = 1, (100,58) = 0.
- Boundaries: (99,50), (164,50), (100,49), (100,70) → in_field=0, pixel_on=0. (163,69) → in_field=1, pixel_on=0 (gap).
- Sweep all codes 0-15 in digit0 across frames → every lit pixel matches the font table. No pixel is lit outside glyph columns; pixel_on is all-0 for codes 11-15.
